// File: rtl/pack_pkg.sv
// Shared constants and the RGB888 to RGB565 conversion used by the pixel packer.
package pack_pkg;

    localparam int PIX_PER_WORD = 8;
    localparam int PIX565_W     = 16;

    // Truncating conversion: keep the top 5/6/5 bits of each channel, no rounding.
    function automatic logic [PIX565_W-1:0] rgb888_to_565(input logic [7:0] r,
                                                          input logic [7:0] g,
                                                          input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/s_fifo_fwft.sv
// Small synchronous first-word-fall-through FIFO; the head word is always on dout.
module s_fifo_fwft #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_rd;
    logic             do_wr;

    // The extra pointer bit tells a full FIFO apart from an empty one; a read frees
    // a slot in the same cycle, so a write while full is accepted when paired with a read.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_rd = rd_en & ~empty;
        do_wr = wr_en & (~full | do_rd);
        dout  = mem[rd_ptr[AW-1:0]];
    end

    // Storage and pointers; contents are cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/post_rgb565_pack.sv
// Converts RGB888 pixels to RGB565, packs eight per 128-bit word and buffers the
// words for the DDR write arbiter, with frame-start, end-of-frame flush and overflow.
module post_rgb565_pack
    import pack_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              I_Clk,
    input  logic              I_Rst_n,
    input  logic              I_V_Sync,
    input  logic              I_H_Sync,
    input  logic              I_RGB_Vaild,
    input  logic [7:0]        I_RGB_Data_r,
    input  logic [7:0]        I_RGB_Data_g,
    input  logic [7:0]        I_RGB_Data_b,
    output logic              O_Wr_Vaild,
    output logic [DATA_W-1:0] O_Wr_Data,
    input  logic              I_Wr_Ready,
    output logic              O_Frame_Start,
    output logic [CNT_W-1:0]  O_Word_Cnt,
    output logic              O_Overflow
);

    logic              r1_v;
    logic              v_rise;
    logic              v_fall;
    logic              pix_take;
    logic [2:0]        pc;
    logic [2:0]        base_pc;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] cur_word;
    logic [15:0]       pix;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_hsync;

    // Line sync carries no information for packing.
    assign unused_hsync = I_H_Sync;

    // Build the word as it stands after this cycle's pixel. A frame start discards
    // any partial word first, and the pixel in the falling-sync cycle still counts
    // so that it is included in the flushed word.
    always_comb begin
        v_rise   = I_V_Sync & ~r1_v;
        v_fall   = ~I_V_Sync & r1_v;
        pix_take = I_RGB_Vaild & (I_V_Sync | r1_v);
        pix      = rgb888_to_565(I_RGB_Data_r, I_RGB_Data_g, I_RGB_Data_b);
        base_pc  = v_rise ? 3'd0 : pc;
        cur_word = v_rise ? '0 : sr;
        if (pix_take) begin
            cur_word[{base_pc, 4'b0000} +: PIX565_W] = pix;
        end
        push = (pix_take && (base_pc == 3'd7)) ||
               (v_fall && (pix_take || (base_pc != 3'd0)));
        pop  = I_Wr_Ready & ~fifo_empty;
    end

    // Pack count and shift register; after a push the register restarts from zero,
    // which is what zero-pads the unfilled lanes of a flushed word.
    always_ff @(posedge I_Clk or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            pc <= '0;
            sr <= '0;
        end else if (push) begin
            pc <= '0;
            sr <= '0;
        end else begin
            pc <= base_pc + {2'b00, pix_take};
            sr <= cur_word;
        end
    end

    // Sync edge register, frame-start pulse, produced-word counter and sticky overflow.
    always_ff @(posedge I_Clk or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            r1_v          <= 1'b0;
            O_Frame_Start <= 1'b0;
            O_Word_Cnt    <= '0;
            O_Overflow    <= 1'b0;
        end else begin
            r1_v          <= I_V_Sync;
            O_Frame_Start <= v_rise;
            if (v_rise) begin
                O_Word_Cnt <= '0;
                O_Overflow <= 1'b0;
            end else begin
                if (push) begin
                    O_Word_Cnt <= O_Word_Cnt + 1'b1;
                end
                if (push && fifo_full && !pop) begin
                    O_Overflow <= 1'b1;
                end
            end
        end
    end

    s_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (I_Clk),
        .rst_n (I_Rst_n),
        .wr_en (push),
        .din   (cur_word),
        .rd_en (I_Wr_Ready),
        .dout  (O_Wr_Data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign O_Wr_Vaild = ~fifo_empty;

endmodule

// File: tb/tb_post_rgb565_pack.sv
// Self-checking bench: a cycle model predicts produced words into a scoreboard queue,
// and every cycle the DUT outputs are compared against the model.
module tb_post_rgb565_pack;

    logic         clk;
    logic         rst_n;
    logic         v_sync;
    logic         h_sync;
    logic         pix_valid;
    logic [7:0]   r_in;
    logic [7:0]   g_in;
    logic [7:0]   b_in;
    logic         wr_valid;
    logic [127:0] wr_data;
    logic         wr_ready;
    logic         frame_start;
    logic [15:0]  word_cnt;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp_q[$];
    logic [127:0] m_word;
    int           m_pc;
    logic [15:0]  m_cnt;
    logic         m_ovf;
    logic         m_fs;
    logic         m_r1;
    int           fs_seen;
    int           pop_seen;

    post_rgb565_pack #(
        .DATA_W     (128),
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .I_Clk         (clk),
        .I_Rst_n       (rst_n),
        .I_V_Sync      (v_sync),
        .I_H_Sync      (h_sync),
        .I_RGB_Vaild   (pix_valid),
        .I_RGB_Data_r  (r_in),
        .I_RGB_Data_g  (g_in),
        .I_RGB_Data_b  (b_in),
        .O_Wr_Vaild    (wr_valid),
        .O_Wr_Data     (wr_data),
        .I_Wr_Ready    (wr_ready),
        .O_Frame_Start (frame_start),
        .O_Word_Cnt    (word_cnt),
        .O_Overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        m_word = '0;
        m_pc   = 0;
        m_cnt  = '0;
        m_ovf  = 1'b0;
        m_fs   = 1'b0;
        m_r1   = 1'b0;
    endtask

    // One clock cycle with the given inputs: compare outputs against the model,
    // take the edge, then advance the model.
    task automatic applyStimulus(input logic v, input logic pv, input logic [7:0] r,
                                 input logic [7:0] g, input logic [7:0] b,
                                 input logic rdy);
        logic         rise;
        logic         fall;
        logic         take;
        logic         pop;
        logic         produced;
        logic [15:0]  p565;
        v_sync    = v;
        pix_valid = pv;
        r_in      = r;
        g_in      = g;
        b_in      = b;
        wr_ready  = rdy;
        h_sync    = $urandom_range(0, 1);
        checkOutput("wr_valid", {127'd0, wr_valid}, {127'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) checkOutput("wr_data", wr_data, exp_q[0]);
        checkOutput("overflow", {127'd0, overflow}, {127'd0, m_ovf});
        checkOutput("word_cnt", {112'd0, word_cnt}, {112'd0, m_cnt});
        checkOutput("frame_start", {127'd0, frame_start}, {127'd0, m_fs});
        if (frame_start) fs_seen++;
        if (wr_valid && rdy) pop_seen++;
        rise = v & ~m_r1;
        fall = ~v & m_r1;
        take = pv & (v | m_r1);
        pop  = rdy && (exp_q.size() > 0);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (rise) begin
            m_pc   = 0;
            m_word = '0;
            m_cnt  = '0;
            m_ovf  = 1'b0;
        end
        if (take) begin
            p565 = {r[7:3], g[7:2], b[7:3]};
            m_word[m_pc*16 +: 16] = p565;
            m_pc++;
        end
        produced = (take && m_pc == 8) || (fall && m_pc != 0);
        if (produced) begin
            m_cnt++;
            if (exp_q.size() < 4) exp_q.push_back(m_word);
            else m_ovf = 1'b1;
            m_word = '0;
            m_pc   = 0;
        end
        m_fs = rise;
        m_r1 = v;
        #1;
    endtask

    task automatic randomPixels(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
        end
    endtask

    logic [127:0] lane_word;
    logic [7:0]   kk;

    initial begin
        modelReset();
        fs_seen   = 0;
        pop_seen  = 0;
        rst_n     = 1'b0;
        v_sync    = 1'b0;
        h_sync    = 1'b0;
        pix_valid = 1'b0;
        r_in      = '0;
        g_in      = '0;
        b_in      = '0;
        wr_ready  = 1'b0;
        #2;
        checkOutput("rst_valid", {127'd0, wr_valid}, 128'd0);
        checkOutput("rst_data", wr_data, 128'd0);
        checkOutput("rst_cnt", {112'd0, word_cnt}, 128'd0);
        checkOutput("rst_ovf", {127'd0, overflow}, 128'd0);
        checkOutput("rst_fs", {127'd0, frame_start}, 128'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame of pure red: one word of 0xF800 lanes.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1);
        checkOutput("red_valid", {127'd0, wr_valid}, 128'd1);
        checkOutput("red_word", wr_data, {8{16'hF800}});
        checkOutput("red_cnt", {112'd0, word_cnt}, 128'd1);
        checkOutput("red_fs_once", fs_seen, 128'd1);

        // Lane ordering: pixel k lands in bits [k*16+15 : k*16].
        lane_word = '0;
        for (int k = 0; k < 8; k++) begin
            kk = 8'(k);
            lane_word[k*16 +: 16] = {kk[4:0], kk[5:0], kk[4:0]};
            applyStimulus(1'b1, 1'b1, 8'(8*k), 8'(4*k), 8'(8*k), 1'b1);
        end
        checkOutput("lane_word", wr_data, lane_word);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // 11 pixels then end of frame: second word zero-padded above lane 2.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        randomPixels(11, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        checkOutput("flush_cnt", {112'd0, word_cnt}, 128'd2);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("flush_pad", {48'd0, wr_data[127:48]}, 128'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("flush_drained", {127'd0, wr_valid}, 128'd0);

        // Overflow: six words with the consumer stalled, four survive.
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        randomPixels(48, 1'b0);
        checkOutput("ovf_set", {127'd0, overflow}, 128'd1);
        checkOutput("ovf_cnt", {112'd0, word_cnt}, 128'd6);
        pop_seen = 0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("ovf_drain_count", pop_seen, 128'd4);
        checkOutput("ovf_sticky", {127'd0, overflow}, 128'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        checkOutput("ovf_clear", {127'd0, overflow}, 128'd0);

        // Full FIFO with push and pop in the same cycle: no overflow.
        randomPixels(39, 1'b0);
        randomPixels(1, 1'b1);
        checkOutput("fullpp_ovf", {127'd0, overflow}, 128'd0);
        checkOutput("fullpp_cnt", {112'd0, word_cnt}, 128'd5);
        pop_seen = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        checkOutput("fullpp_drain_count", pop_seen, 128'd4);

        // Partial word, sync drop and restart: the new word holds only new pixels.
        randomPixels(5, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h12, 8'h34, 8'h56, 1'b1);
        randomPixels(7, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        // Mid-frame reset clears outputs without waiting for a clock edge.
        randomPixels(10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {127'd0, wr_valid}, 128'd0);
        checkOutput("mid_rst_cnt", {112'd0, word_cnt}, 128'd0);
        checkOutput("mid_rst_ovf", {127'd0, overflow}, 128'd0);
        modelReset();
        v_sync    = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        randomPixels(8, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
